// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 measurement scheduler.
//   state_t    : scheduler FSM states
//   ms_div     : system clocks per 1 ms tick
//   cnt_width  : bit width needed to hold 0..max_val
//   plausible  : range check on a reading (humidity int 20..95, temperature int 0..50)
package dht11_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAP,
    ST_START,
    ST_WAIT_RESP
  } state_t;

  localparam logic [7:0] HUMI_MIN = 8'd20;
  localparam logic [7:0] HUMI_MAX = 8'd95;
  localparam logic [7:0] TEMP_MAX = 8'd50;

  function automatic int unsigned ms_div(input int unsigned clk_hz);
    return (clk_hz < 1000) ? 1 : clk_hz / 1000;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Temperature integer part is unsigned, so the lower bound of 0 is implicit.
  function automatic logic plausible(input logic [15:0] temp, input logic [15:0] humi);
    return (humi[15:8] >= HUMI_MIN) && (humi[15:8] <= HUMI_MAX) && (temp[15:8] <= TEMP_MAX);
  endfunction

endpackage

// File: rtl/dht11_sched_if.sv
// Handshake/data bundle between the scheduler, the DHT11 core and register logic.
//   slave  : scheduler side (inputs from core/controls, status outputs)
//   master : driving side (core model, controls, status consumers)
interface dht11_sched_if;
  logic        iEnable;
  logic        iTrigReq;
  logic        oDhtStart;
  logic        iDhtValid;
  logic [15:0] iDhtTemp;
  logic [15:0] iDhtHumi;
  logic [15:0] oTemp;
  logic [15:0] oHumi;
  logic        oDataValid;
  logic        oNewData;
  logic        oBusy;
  logic        oErr;
  logic [7:0]  oErrCnt;

  modport slave (
    input  iEnable, iTrigReq, iDhtValid, iDhtTemp, iDhtHumi,
    output oDhtStart, oTemp, oHumi, oDataValid, oNewData, oBusy, oErr, oErrCnt
  );

  modport master (
    output iEnable, iTrigReq, iDhtValid, iDhtTemp, iDhtHumi,
    input  oDhtStart, oTemp, oHumi, oDataValid, oNewData, oBusy, oErr, oErrCnt
  );
endinterface

// File: rtl/dht11_sched_ms_tick_gen.sv
// Free-running prescaler producing a registered one-cycle tick every P_DIV clocks.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : one-cycle pulse every P_DIV cycles
module ms_tick_gen
  import dht11_pkg::*;
#(
  parameter int unsigned P_DIV = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned W = cnt_width(P_DIV - 1);
  localparam logic [W-1:0] LAST = W'(P_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/dht11_sched.sv
// DHT11 measurement scheduler: issues core start pulses periodically (iEnable)
// or on request (iTrigReq), enforces the minimum inter-start gap, times out
// missing responses with bounded retries, and latches accepted readings.
//   iClk, iRstn : clock, asynchronous active-low reset
//   bus (slave) : controls, core handshake, readings and status/error outputs
// Optional build macro DHT_SCHED_PLAUS_EN: reject out-of-range readings and
// treat them like a timeout.
module dht11_sched
  import dht11_pkg::*;
#(
  parameter int unsigned P_SYS_CLK_HZ      = 100_000_000,
  parameter int unsigned P_PERIOD_MS       = 2000,
  parameter int unsigned P_MIN_GAP_MS      = 1000,
  parameter int unsigned P_RESP_TIMEOUT_MS = 30,
  parameter int unsigned P_MAX_RETRY       = 3
) (
  input logic          iClk,
  input logic          iRstn,
  dht11_sched_if.slave bus
);

  localparam int unsigned GW = cnt_width(P_MIN_GAP_MS);
  localparam int unsigned PW = cnt_width(P_PERIOD_MS);
  localparam int unsigned TW = cnt_width(P_RESP_TIMEOUT_MS);
  localparam int unsigned RW = cnt_width(P_MAX_RETRY);
  localparam logic [GW-1:0] GAP_MAX   = GW'(P_MIN_GAP_MS);
  localparam logic [PW-1:0] PER_MAX   = PW'(P_PERIOD_MS);
  localparam logic [TW-1:0] RESP_MAX  = TW'(P_RESP_TIMEOUT_MS);
  localparam logic [RW-1:0] RETRY_MAX = RW'(P_MAX_RETRY);

  logic          tick;
  state_t        state;
  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] resp_cnt;
  logic [RW-1:0] retry;
  logic          trig_pend;
  logic          gap_sat, period_sat, resp_to, request, accept, attempt_fail;

  ms_tick_gen #(.P_DIV(ms_div(P_SYS_CLK_HZ))) u_tick (
    .clk  (iClk),
    .rst_n(iRstn),
    .tick (tick)
  );

  assign gap_sat    = (gap_cnt == GAP_MAX);
  assign period_sat = (period_cnt == PER_MAX);
  assign resp_to    = (resp_cnt == RESP_MAX);
  assign request    = trig_pend | (bus.iEnable & period_sat);

`ifdef DHT_SCHED_PLAUS_EN
  assign accept = plausible(bus.iDhtTemp, bus.iDhtHumi);
`else
  assign accept = 1'b1;
`endif

  // A rejected reading takes the same path as a missing one.
  assign attempt_fail = resp_to | (bus.iDhtValid & ~accept);

  // Gap and period counters restart on every issued start; the gap counter
  // counting from reset doubles as the power-up settle time.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      gap_cnt    <= '0;
      period_cnt <= '0;
      trig_pend  <= 1'b0;
    end else begin
      if (state == ST_START) begin
        gap_cnt    <= '0;
        period_cnt <= '0;
      end else begin
        if (tick && !gap_sat) gap_cnt <= gap_cnt + 1'b1;
        if (tick && bus.iEnable && !period_sat) period_cnt <= period_cnt + 1'b1;
      end
      if (bus.iTrigReq) trig_pend <= 1'b1;
      else if (state == ST_START) trig_pend <= 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state          <= ST_IDLE;
      resp_cnt       <= '0;
      retry          <= '0;
      bus.oDhtStart  <= 1'b0;
      bus.oTemp      <= '0;
      bus.oHumi      <= '0;
      bus.oDataValid <= 1'b0;
      bus.oNewData   <= 1'b0;
      bus.oBusy      <= 1'b0;
      bus.oErr       <= 1'b0;
      bus.oErrCnt    <= '0;
    end else begin
      bus.oDhtStart <= 1'b0;
      bus.oNewData  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (request) begin
            if (gap_sat) begin
              state         <= ST_START;
              bus.oDhtStart <= 1'b1;
              bus.oBusy     <= 1'b1;
            end else begin
              state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_sat) begin
            state         <= ST_START;
            bus.oDhtStart <= 1'b1;
            bus.oBusy     <= 1'b1;
          end
        end
        ST_START: begin
          resp_cnt <= '0;
          state    <= ST_WAIT_RESP;
        end
        ST_WAIT_RESP: begin
          // Valid is tested first so a reading coincident with timeout wins.
          if (bus.iDhtValid && accept) begin
            bus.oTemp      <= bus.iDhtTemp;
            bus.oHumi      <= bus.iDhtHumi;
            bus.oNewData   <= 1'b1;
            bus.oDataValid <= 1'b1;
            bus.oErr       <= 1'b0;
            bus.oBusy      <= 1'b0;
            retry          <= '0;
            state          <= ST_IDLE;
          end else if (attempt_fail) begin
            bus.oBusy <= 1'b0;
            if (retry < RETRY_MAX) begin
              retry <= retry + 1'b1;
              state <= ST_GAP;
            end else begin
              bus.oErr <= 1'b1;
              if (bus.oErrCnt != 8'hFF) bus.oErrCnt <= bus.oErrCnt + 1'b1;
              retry <= '0;
              state <= ST_IDLE;
            end
          end else if (tick) begin
            resp_cnt <= resp_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_sched.sv
module tb_dht11_sched;

  localparam int unsigned CLK_HZ = 8000;
  localparam int unsigned DIV    = 8;
  localparam int unsigned PER    = 200;
  localparam int unsigned GAP    = 100;
  localparam int unsigned TO     = 30;

  typedef struct {
    logic [15:0] t;
    logic [15:0] h;
  } rd_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   newdata_cnt = 0;
  rd_t  q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dht11_sched_if bus ();
  dht11_sched_if bus0 ();

  dht11_sched #(
    .P_SYS_CLK_HZ(CLK_HZ), .P_PERIOD_MS(PER), .P_MIN_GAP_MS(GAP),
    .P_RESP_TIMEOUT_MS(TO), .P_MAX_RETRY(3)
  ) u_dut (.iClk(clk), .iRstn(rst_n), .bus(bus));

  dht11_sched #(
    .P_SYS_CLK_HZ(CLK_HZ), .P_PERIOD_MS(PER), .P_MIN_GAP_MS(GAP),
    .P_RESP_TIMEOUT_MS(TO), .P_MAX_RETRY(0)
  ) u_dut0 (.iClk(clk), .iRstn(rst_n), .bus(bus0));

  function automatic int ms(input int n);
    return n * DIV;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Scoreboard: every accepted reading pops the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.oNewData === 1'b1) begin
      newdata_cnt++;
      chk("newdata_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        rd_t e;
        e = q.pop_front();
        chk("temp", 32'(bus.oTemp), 32'(e.t));
        chk("humi", 32'(bus.oHumi), 32'(e.h));
      end
    end
    if (rst_n === 1'b1 && bus0.oNewData === 1'b1) chk("dut0_newdata", 32'd1, 32'd0);
  end

  initial begin
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int max_cyc, output bit seen, output int at);
    seen = 1'b0;
    at = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      step();
      if (bus.oDhtStart === 1'b1) begin
        seen = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic wait_idle(input int max_cyc, output bit seen, output int at);
    seen = 1'b0;
    at = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      step();
      if (bus.oBusy === 1'b0) begin
        seen = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic respond(input int dly_ms, input logic [15:0] t, input logic [15:0] h,
                         input bit accepted);
    repeat (ms(dly_ms)) @(posedge clk);
    #1;
    bus.iDhtTemp  = t;
    bus.iDhtHumi  = h;
    bus.iDhtValid = 1'b1;
    if (accepted) q.push_back('{t, h});
    step();
    bus.iDhtValid = 1'b0;
  endtask

  task automatic trig();
    bus.iTrigReq = 1'b1;
    step();
    bus.iTrigReq = 1'b0;
  endtask

  task automatic idle_ms(input int n);
    repeat (ms(n)) @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    int t1, t2, s3, s4, s, sp, f, d, c, lat, sphase, nd;

    rst_n = 1'b0;
    bus.iEnable = 1'b0;  bus.iTrigReq = 1'b0;  bus.iDhtValid = 1'b0;
    bus.iDhtTemp = '0;   bus.iDhtHumi = '0;
    bus0.iEnable = 1'b0; bus0.iTrigReq = 1'b0; bus0.iDhtValid = 1'b0;
    bus0.iDhtTemp = '0;  bus0.iDhtHumi = '0;
    repeat (3) step();

    chk("rst_start", 32'(bus.oDhtStart), 32'd0);
    chk("rst_busy", 32'(bus.oBusy), 32'd0);
    chk("rst_valid", 32'(bus.oDataValid), 32'd0);
    chk("rst_err", 32'(bus.oErr), 32'd0);
    chk("rst_errcnt", 32'(bus.oErrCnt), 32'd0);
    chk("rst_temp", 32'(bus.oTemp), 32'd0);
    chk("rst_humi", 32'(bus.oHumi), 32'd0);

    // Periodic mode from reset.
    bus.iEnable = 1'b1;
    rst_n = 1'b1;
    c = cyc;
    wait_start(ms(PER + 50), seen, t1);
    chk("first_start_seen", 32'(seen), 32'd1);
    chk_range("first_start_time", t1 - c, ms(GAP) - DIV, ms(PER) + 2 * DIV);
    chk("busy_in_start", 32'(bus.oBusy), 32'd1);
    respond(25, 16'h1E00, 16'h3700, 1'b1);
    chk("datavalid", 32'(bus.oDataValid), 32'd1);
    chk("busy_after_data", 32'(bus.oBusy), 32'd0);
    chk("err_after_data", 32'(bus.oErr), 32'd0);
    wait_start(ms(PER + 20), seen, t2);
    chk("second_start_seen", 32'(seen), 32'd1);
    chk_range("period_spacing", t2 - t1, ms(PER) - DIV - 3, ms(PER) + DIV + 3);
    respond(10, 16'h1F05, 16'h3A00, 1'b1);
    bus.iEnable = 1'b0;
    wait_start(ms(150), seen, s);
    chk("no_start_disabled", 32'(seen), 32'd0);

    // On-demand triggers, second pair merged and held off by the gap.
    c = cyc;
    trig();
    wait_start(10, seen, s3);
    chk("trig_start_seen", 32'(seen), 32'd1);
    lat = s3 - c;
    chk_range("trig_latency", lat, 1, 3);
    respond(10, 16'h1C00, 16'h3500, 1'b1);
    while (cyc < s3 + ms(20)) step();
    trig();
    while (cyc < s3 + ms(30)) step();
    trig();
    wait_start(ms(90), seen, s4);
    chk("gap_start_seen", 32'(seen), 32'd1);
    chk_range("gap_holdoff", s4 - s3, ms(GAP) - DIV - 3, ms(GAP) + DIV + 3);
    respond(10, 16'h1D02, 16'h3800, 1'b1);
    wait_start(ms(150), seen, s);
    chk("merged_single_start", 32'(seen), 32'd0);

    // Core silent: first attempt plus three retries, then error.
    trig();
    wait_start(10, seen, s);
    chk("silent_start1", 32'(seen), 32'd1);
    sphase = s % DIV;
    wait_idle(ms(TO + 10), seen, f);
    chk("timeout_seen", 32'(seen), 32'd1);
    d = f - s;
    chk_range("timeout_window", d, ms(TO) - DIV, ms(TO) + 4);
    for (int k = 2; k <= 4; k++) begin
      sp = s;
      chk("err_before_exhaust", 32'(bus.oErr), 32'd0);
      wait_start(ms(GAP + 10), seen, s);
      chk("retry_start_seen", 32'(seen), 32'd1);
      chk_range("retry_spacing", s - sp, ms(GAP) - DIV - 3, ms(GAP) + DIV + 3);
    end
    chk("errcnt_before_exhaust", 32'(bus.oErrCnt), 32'd0);
    wait_idle(ms(TO + 10), seen, f);
    chk("last_timeout_seen", 32'(seen), 32'd1);
    chk("err_set", 32'(bus.oErr), 32'd1);
    chk("errcnt_1", 32'(bus.oErrCnt), 32'd1);
    chk("temp_held", 32'(bus.oTemp), 32'h1D02);
    chk("humi_held", 32'(bus.oHumi), 32'h3800);
    chk("datavalid_held", 32'(bus.oDataValid), 32'd1);
    bus.iDhtTemp = 16'h5555;
    bus.iDhtHumi = 16'hAAAA;
    bus.iDhtValid = 1'b1;
    step();
    bus.iDhtValid = 1'b0;
    step();
    chk("stray_valid_ignored", 32'(bus.oTemp), 32'h1D02);
    wait_start(ms(150), seen, s);
    chk("no_fifth_start", 32'(seen), 32'd0);

    // Recovery from error.
    trig();
    wait_start(10, seen, s);
    chk("recover_start_seen", 32'(seen), 32'd1);
    respond(10, 16'h1400, 16'h2800, 1'b1);
    chk("err_cleared", 32'(bus.oErr), 32'd0);
    chk("errcnt_kept", 32'(bus.oErrCnt), 32'd1);

    // Reading in the very cycle the timeout fires: start on the same tick
    // phase as the silent attempt so the timeout lands on cycle s+d-1.
    idle_ms(GAP);
    for (int i = 0; i < int'(DIV) && ((cyc + lat) % DIV) != sphase; i++) step();
    trig();
    wait_start(10, seen, s);
    chk("align_start_seen", 32'(seen), 32'd1);
    chk("phase_align", 32'(s % DIV), 32'(sphase));
    nd = newdata_cnt;
    while (cyc < s + d - 1) step();
    bus.iDhtTemp = 16'h1A00;
    bus.iDhtHumi = 16'h3C00;
    bus.iDhtValid = 1'b1;
    q.push_back('{16'h1A00, 16'h3C00});
    step();
    bus.iDhtValid = 1'b0;
    repeat (2) step();
    chk("coincident_accepted", 32'(newdata_cnt - nd), 32'd1);
    chk("coincident_no_err", 32'(bus.oErr), 32'd0);
    chk("coincident_idle", 32'(bus.oBusy), 32'd0);
    wait_start(ms(150), seen, s);
    chk("coincident_no_retry", 32'(seen), 32'd0);
    chk("coincident_errcnt", 32'(bus.oErrCnt), 32'd1);

`ifdef DHT_SCHED_PLAUS_EN
    trig();
    wait_start(10, seen, s);
    chk("plaus_start_seen", 32'(seen), 32'd1);
    nd = newdata_cnt;
    respond(10, 16'h1E00, 16'h6400, 1'b0);
    repeat (2) step();
    chk("plaus_rejected", 32'(newdata_cnt - nd), 32'd0);
    chk("plaus_temp_held", 32'(bus.oTemp), 32'h1A00);
    sp = s;
    wait_start(ms(GAP + 10), seen, s);
    chk("plaus_retry_seen", 32'(seen), 32'd1);
    chk_range("plaus_retry_spacing", s - sp, ms(GAP) - DIV - 3, ms(GAP) + DIV + 3);
    respond(10, 16'h1E00, 16'h3200, 1'b1);
    chk("plaus_err", 32'(bus.oErr), 32'd0);
    idle_ms(GAP);
`endif

    // Reset in the middle of an attempt.
    trig();
    wait_start(10, seen, s);
    chk("pre_reset_start", 32'(seen), 32'd1);
    idle_ms(5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.oBusy), 32'd0);
    chk("mid_rst_valid", 32'(bus.oDataValid), 32'd0);
    chk("mid_rst_errcnt", 32'(bus.oErrCnt), 32'd0);
    chk("mid_rst_temp", 32'(bus.oTemp), 32'd0);
    chk("mid_rst_humi", 32'(bus.oHumi), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    wait_start(ms(80), seen, s);
    chk("no_start_after_reset", 32'(seen), 32'd0);

    // Zero-retry instance: the first timeout is an error.
    idle_ms(30);
    bus0.iTrigReq = 1'b1;
    step();
    bus0.iTrigReq = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (bus0.oDhtStart === 1'b1) seen = 1'b1;
    end
    chk("dut0_start_seen", 32'(seen), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < int'(ms(TO + 10)) && !seen; i++) begin
      step();
      if (bus0.oBusy === 1'b0) seen = 1'b1;
    end
    chk("dut0_timeout_seen", 32'(seen), 32'd1);
    chk("dut0_err", 32'(bus0.oErr), 32'd1);
    chk("dut0_errcnt", 32'(bus0.oErrCnt), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < int'(ms(150)); i++) begin
      step();
      if (bus0.oDhtStart === 1'b1) seen = 1'b1;
    end
    chk("dut0_no_retry", 32'(seen), 32'd0);

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
